// File: rtl/oled_hex_logger.sv
// oled_hex_logger: logs incoming bytes as uppercase hex text on a 4x16-character
// OLED text buffer. Each accepted byte (or a clear request) updates the buffer
// once and then runs one EN/FIN refresh handshake with the downstream OLED
// controller. Each refresh phase is guarded by a timeout that raises a sticky
// error flag.
module oled_hex_logger #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic         clr,
    output logic         oled_en,
    input  logic         oled_fin,
    output logic [127:0] page0,
    output logic [127:0] page1,
    output logic [127:0] page2,
    output logic [127:0] page3,
    output logic         err
);

    localparam logic [7:0]  SPACE    = 8'h20;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        REQ,
        WAIT_LOW
    } state_t;

    state_t         state_q;
    logic [4:0]     cursor_q;    // next byte slot; only moves in WRITE
    logic [7:0]     byte_q;      // byte captured at acceptance
    logic           clear_q;     // pending operation is a clear
    logic [31:0]    tmo_cnt_q;   // cycles spent in the current REQ / WAIT_LOW
    logic           err_q;
    // Display text: character j (page j/16, position j%16) at [511-8j -: 8],
    // so byte slot k (two characters) sits at [511-16k -: 16].
    logic [511:0]   disp_q;

    logic [15:0]    hex_pair_d;
    logic [511:0]   disp_d;
    logic           tmo_hit;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign hex_pair_d = {hex_ascii(byte_q[7:4]), hex_ascii(byte_q[3:0])};
    assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

    // Display contents to be committed at the end of WRITE.
    always_comb begin
        // NOTE: disp_d is given a default first so every path assigns it and no latch is inferred.
        disp_d = disp_q;
        if (clear_q) begin
            disp_d = {64{SPACE}};
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (cursor_q == 5'(k)) begin
                    disp_d[511 - 16*k -: 16] = hex_pair_d;
                end
            end
        end
    end

    // Control FSM, text buffer, cursor, timeout counter and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cursor_q  <= 5'd0;
            byte_q    <= 8'h00;
            clear_q   <= 1'b0;
            tmo_cnt_q <= 32'd0;
            err_q     <= 1'b0;
            // NOTE: the text buffer is reset on purpose so the panel shows blanks
            // after reset; plain storage arrays elsewhere normally stay unreset.
            disp_q    <= {64{SPACE}};
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        // A clear wins over a simultaneously offered byte.
                        clear_q <= 1'b1;
                        state_q <= WRITE;
                    end else if (in_valid) begin
                        clear_q <= 1'b0;
                        byte_q  <= in_data;
                        state_q <= WRITE;
                    end
                end

                WRITE: begin
                    disp_q    <= disp_d;
                    cursor_q  <= clear_q ? 5'd0 : cursor_q + 5'd1;
                    tmo_cnt_q <= 32'd0;
                    state_q   <= REQ;
                end

                REQ: begin
                    if (oled_fin) begin
                        tmo_cnt_q <= 32'd0;
                        state_q   <= WAIT_LOW;
                    end else if (tmo_hit) begin
                        err_q     <= 1'b1;
                        tmo_cnt_q <= 32'd0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end

                WAIT_LOW: begin
                    if (!oled_fin) begin
                        tmo_cnt_q <= 32'd0;
                        state_q   <= IDLE;
                    end else if (tmo_hit) begin
                        err_q     <= 1'b1;
                        tmo_cnt_q <= 32'd0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign in_ready = (state_q == IDLE);
    assign oled_en  = (state_q == REQ);
    assign err      = err_q;

    assign page0 = disp_q[511:384];
    assign page1 = disp_q[383:256];
    assign page2 = disp_q[255:128];
    assign page3 = disp_q[127:0];

endmodule

// File: doc/oled_hex_logger.md
OLED_HEX_LOGGER -- requirements
Module: oled_hex_logger

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000, is the maximum number of cycles to wait for each oled_fin edge before aborting a refresh.
REQ-002 CLK  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  a byte is offered on in_data.
REQ-005 in_data  input  8  byte to log.
REQ-006 in_ready  output  1  the block can accept a byte or a clear request.
REQ-007 clr  input  1  clear request, sampled only when in_ready=1.
REQ-008 oled_en  output  1  refresh request to the downstream OLED controller EN.
REQ-009 oled_fin  input  1  done flag from the downstream OLED controller FIN.
REQ-010 page0..page3  output  128 each  display text, 16 ASCII characters per page; character 0 occupies bits [127:120].
REQ-011 err  output  1  sticky flag indicating a refresh timed out.

Function
REQ-012 States SHALL be IDLE, WRITE, REQ and WAIT_LOW.
- in_ready=1 only in IDLE.
- oled_en=1 only in REQ (decoded from the state register).
REQ-013 Byte handshake: in IDLE, when in_valid=1 and clr=0, the block SHALL capture in_data and cursor, then go to WRITE.
REQ-014 Clear handshake: in IDLE, when clr=1 (with or without in_valid), the block SHALL go to WRITE with a clear operation; clr SHALL take priority and in_data SHALL be dropped.
REQ-015 WRITE lasts one cycle and then goes to REQ.
- Byte operation: write two uppercase hex ASCII characters for the captured byte, then increment cursor.
- Clear operation: set all 64 characters to 0x20 and set cursor to 0.
REQ-016 Cursor placement: the cursor is 5 bits (0..31). Cursor k SHALL map to page k[4:3], characters 2*k[2:0] (high nibble) and 2*k[2:0]+1 (low nibble).
REQ-017 Nibble encoding: 0-9 SHALL map to 0x30-0x39 and A-F to 0x41-0x46.
REQ-018 Cursor wrap: after cursor 31 the cursor SHALL wrap to 0, and later bytes SHALL overwrite in place with no implicit clear.
REQ-019 REQ state: hold oled_en=1 until oled_fin=1 is sampled, then go to WAIT_LOW.
REQ-020 WAIT_LOW state: hold oled_en=0 until oled_fin=0 is sampled, then go to IDLE.
REQ-021 page0..page3 SHALL be constant from the WRITE→REQ edge until the block re-enters WRITE, so the downstream latch sees stable data.
REQ-022 Latency: for a byte accepted at edge E0, pages SHALL be updated at E1 and oled_en SHALL be high in the cycle after E1; the earliest next acceptance is the cycle after leaving WAIT_LOW.
REQ-023 Timeout counter: a 32-bit counter SHALL clear on entering REQ and on entering WAIT_LOW, and increment each cycle in those states.
REQ-024 Timeout abort: if the counter reaches TIMEOUT_CYCLES-1 without the awaited oled_fin level, the block SHALL set err=1 and return to IDLE with oled_en=0.
REQ-025 Downstream initialisation: oled_fin held low during downstream initialisation SHALL simply extend REQ; a timeout is the only abort.
REQ-026 err SHALL clear only on RST; the block SHALL continue to operate normally after err is set.
REQ-027 oled_fin already high on entry to REQ SHALL be treated as completion on the first REQ cycle.

Reset
REQ-028 On RST=1 at a clock edge:
- state=IDLE, cursor=0, timeout counter=0, err=0, oled_en=0
- in_ready=1 in the following cycle
- all page characters=0x20
REQ-029 RST SHALL override any state, including mid-REQ: oled_en SHALL drop in the cycle after the reset edge, and any pending byte SHALL be discarded.

Verification
REQ-030 Reset, then offer byte 0xA5 while an oled_fin model raises FIN 10 cycles after EN → page0[127:112]=0x4135, page0[111:0] all 0x20, one EN pulse, in_ready back high after FIN falls.
REQ-031 Send 33 bytes 0x00..0x20 → after the 32nd byte page3[15:0]=0x3146 ("1F"); the 33rd byte (0x20) overwrites page0[127:112] with 0x3230, and page1 characters are unchanged.
REQ-032 In IDLE assert clr=1 together with in_valid=1 and in_data=0xFF → all pages 0x20, cursor=0, one refresh cycle runs, and the 0xFF byte does not appear.
REQ-033 Hold oled_fin=0 with TIMEOUT_CYCLES=100 → oled_en high for exactly 100 cycles, then err=1, IDLE, and the next byte is still accepted and refreshed.
REQ-034 Assert RST while in REQ after two bytes → next cycle oled_en=0, pages all 0x20, err=0, cursor=0.
REQ-035 Hold in_valid=1 continuously with oled_fin high for a single cycle → exactly one byte accepted per refresh cycle, and in_ready=0 throughout WRITE, REQ and WAIT_LOW.
